// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared types, encodings and condition check for the multicycle control unit
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_EXMUL    = 4'd8,
    S_ALUWB    = 4'd9,
    S_LINK     = 4'd10,
    S_BRANCH   = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_MUL = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] SRCB_ZERO = 2'b11;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // flags are {N, Z, C, V}
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: cond_check = z;
      COND_NE: cond_check = ~z;
      COND_CS: cond_check = c;
      COND_CC: cond_check = ~c;
      COND_MI: cond_check = n;
      COND_PL: cond_check = ~n;
      COND_VS: cond_check = v;
      COND_VC: cond_check = ~v;
      COND_HI: cond_check = c & ~z;
      COND_LS: cond_check = ~c | z;
      COND_GE: cond_check = (n == v);
      COND_LT: cond_check = (n != v);
      COND_GT: cond_check = ~z & (n == v);
      COND_LE: cond_check = z | (n != v);
      COND_AL: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_cond_unit.sv
// rtl/mc_cond_unit.sv - NZCV flag register, condition evaluation and write-enable gating
module mc_cond_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       pc_w,
  output logic       reg_write,
  output logic       mem_write,
  output logic       pc_write
);
  import mc_ctrl_pkg::*;

  logic [3:0] flags_q, flags_d;
  logic       cond_ex;

  // condition from registered flags only; flag_w[1] loads NZ, flag_w[0] loads CV
  always_comb begin
    flags_d = flags_q;
    cond_ex = cond_check(cond, flags_q);
    if (flag_w[1] && cond_ex) flags_d[3:2] = alu_flags[3:2];
    if (flag_w[0] && cond_ex) flags_d[1:0] = alu_flags[1:0];
  end

  // architectural flags register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= 4'b0000;
    else        flags_q <= flags_d;
  end

  assign reg_write = reg_w & cond_ex;
  assign mem_write = mem_w & cond_ex;
  assign pc_write  = pc_w  & cond_ex;

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - Moore FSM controller for the shared-memory multicycle ARM datapath
module multicycle_control_unit #(
  parameter bit ENABLE_MUL = 1'b1,
  parameter bit ENABLE_BL  = 1'b1
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ALUControl,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic        WA3Src,
  output logic        InstrDone
);
  import mc_ctrl_pkg::*;

  state_t     state_q, state_d;
  logic [1:0] op;
  logic [3:0] funct;
  logic       s_bit, rd_pc, is_mul;
  logic       dp_known, dp_cmp, dp_arith, wb_ok;
  logic [2:0] dp_alu;
  logic       pc_uncond, pc_w, reg_w, mem_w, ir_w, done;
  logic [1:0] flag_w;
  logic       pc_gated, reg_gated, mem_gated;
  logic       unused_bits;

  assign op          = Instr[27:26];
  assign funct       = Instr[24:21];
  assign s_bit       = Instr[20];
  assign rd_pc       = (Instr[15:12] == 4'hF);
  assign is_mul      = ENABLE_MUL && (op == OP_DP) && !Instr[25] && (Instr[7:4] == 4'b1001);
  assign wb_ok       = dp_known | is_mul;
  assign unused_bits = ^{Instr[19:16], Instr[11:8], Instr[3:0]};

  // data-processing function decode; unknown codes fall back to ADD with no writes
  always_comb begin
    dp_alu   = ALU_ADD;
    dp_known = 1'b0;
    dp_cmp   = 1'b0;
    dp_arith = 1'b0;
    case (funct)
      4'b0100: begin dp_alu = ALU_ADD; dp_known = 1'b1; dp_arith = 1'b1; end
      4'b0010: begin dp_alu = ALU_SUB; dp_known = 1'b1; dp_arith = 1'b1; end
      4'b0000: begin dp_alu = ALU_AND; dp_known = 1'b1; end
      4'b1100: begin dp_alu = ALU_ORR; dp_known = 1'b1; end
      4'b1010: begin dp_alu = ALU_SUB; dp_known = 1'b1; dp_arith = 1'b1; dp_cmp = 1'b1; end
      default: ;
    endcase
  end

  // state register; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // next state and Moore outputs
  always_comb begin
    state_d    = state_q;
    pc_uncond  = 1'b0;
    pc_w       = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    ir_w       = 1'b0;
    done       = 1'b0;
    flag_w     = 2'b00;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    WA3Src     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_w      = 1'b1;
        pc_uncond = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_FOUR;
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = Instr[25] ? S_EXECI : (is_mul ? S_EXMUL : S_EXECR);
          OP_BR:   state_d = (ENABLE_BL && Instr[24]) ? S_LINK : S_BRANCH;
          default: begin state_d = S_FETCH; done = 1'b1; end
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        state_d = Instr[20] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_w     = 1'b1;
        pc_w      = rd_pc;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc  = 1'b1;
        mem_w   = 1'b1;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_REG;
        ALUControl = dp_alu;
        flag_w     = (s_bit && dp_known) ? {1'b1, dp_arith} : 2'b00;
        if (dp_cmp) begin
          done    = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_EXMUL: begin
        ALUControl = ALU_MUL;
        flag_w     = {s_bit, 1'b0};
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = wb_ok;
        pc_w    = wb_ok & rd_pc;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_LINK: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_ZERO;
        ResultSrc = RES_ALURESULT;
        WA3Src    = 1'b1;
        reg_w     = 1'b1;
        state_d   = S_BRANCH;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        pc_w      = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  mc_cond_unit u_cond (
    .clk       (clk),
    .rst_n     (Reset),
    .cond      (Instr[31:28]),
    .alu_flags (ALUFlags),
    .flag_w    (flag_w),
    .reg_w     (reg_w),
    .mem_w     (mem_w),
    .pc_w      (pc_w),
    .reg_write (reg_gated),
    .mem_write (mem_gated),
    .pc_write  (pc_gated)
  );

  assign ImmSrc    = op;
  assign RegSrc    = {(op == OP_MEM) && !Instr[20], (op == OP_BR)};
  assign PCWrite   = Reset & (pc_uncond | pc_gated);
  assign IRWrite   = Reset & ir_w;
  assign RegWrite  = Reset & reg_gated;
  assign MemWrite  = Reset & mem_gated;
  assign InstrDone = Reset & done;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed vector bench for multicycle_control_unit
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [2:0] alu;
    logic       srca;
    logic [1:0] srcb;
    logic       regw;
    logic       wa3;
    logic       done;
  } ctl_t;

  typedef struct packed {
    logic [31:0]    instr;
    logic [3:0]     flags;
    logic [2:0]     n;
    logic [1:0]     imm;
    logic [1:0]     rsrc;
    ctl_t [4:0]     exp;
  } vec_t;

  logic        clk;
  logic        Reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite, WA3Src, InstrDone;
  logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];
  ctl_t cf, cd, cdu, ma, mr, mwb, cmpx, exm;

  multicycle_control_unit #(.ENABLE_MUL(1'b1), .ENABLE_BL(1'b1)) dut (
    .clk(clk), .Reset(Reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .RegWrite(RegWrite), .WA3Src(WA3Src), .InstrDone(InstrDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ctl_t o(int pcw, int adr, int memw, int irw, int res, int alu,
                             int srca, int srcb, int regw, int wa3, int done);
    ctl_t c;
    c.pcw  = 1'(pcw);  c.adr = 1'(adr);   c.memw = 1'(memw); c.irw = 1'(irw);
    c.res  = 2'(res);  c.alu = 3'(alu);   c.srca = 1'(srca); c.srcb = 2'(srcb);
    c.regw = 1'(regw); c.wa3 = 1'(wa3);   c.done = 1'(done);
    return c;
  endfunction

  function automatic ctl_t exr(int alu);          return o(0,0,0,0,0,alu,0,0,0,0,0); endfunction
  function automatic ctl_t exi(int alu);          return o(0,0,0,0,0,alu,0,1,0,0,0); endfunction
  function automatic ctl_t wb(int regw, int pcw); return o(pcw,0,0,0,0,0,0,0,regw,0,1); endfunction
  function automatic ctl_t br(int pcw);           return o(pcw,0,0,0,2,0,0,1,0,0,1); endfunction
  function automatic ctl_t lk(int regw);          return o(0,0,0,0,2,0,1,3,regw,1,0); endfunction
  function automatic ctl_t mw(int memw);          return o(0,1,memw,0,0,0,0,0,0,0,1); endfunction

  function automatic void add(logic [31:0] instr, int fl, int n, int imm, int rsrc,
                              ctl_t c0, ctl_t c1, ctl_t c2, ctl_t c3, ctl_t c4);
    vec_t v;
    v.instr = instr; v.flags = 4'(fl); v.n = 3'(n); v.imm = 2'(imm); v.rsrc = 2'(rsrc);
    v.exp[0] = c0; v.exp[1] = c1; v.exp[2] = c2; v.exp[3] = c3; v.exp[4] = c4;
    vecs.push_back(v);
  endfunction

  function automatic ctl_t act_ctl();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
            ALUSrcA, ALUSrcB, RegWrite, WA3Src, InstrDone};
  endfunction

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // entered just after an edge with the DUT in FETCH; leaves it in FETCH again
  task automatic run_vec(input int idx, input vec_t v);
    ctl_t act;
    Instr    = v.instr;
    ALUFlags = v.flags;
    #1;
    total++;
    if ({ImmSrc, RegSrc} !== {v.imm, v.rsrc}) begin
      bad++;
      $display("FAIL vec%0d imm_regsrc instr=%h got=%b want=%b", idx, v.instr,
               {ImmSrc, RegSrc}, {v.imm, v.rsrc});
    end
    for (int c = 0; c < int'(v.n); c++) begin
      act = act_ctl();
      total++;
      if (act !== v.exp[c]) begin
        bad++;
        $display("FAIL vec%0d cycle%0d instr=%h got=%b want=%b", idx, c, v.instr, act, v.exp[c]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    cf   = o(1,0,0,1,2,0,1,2,0,0,0);
    cd   = o(0,0,0,0,0,0,1,2,0,0,0);
    cdu  = o(0,0,0,0,0,0,1,2,0,0,1);
    ma   = o(0,0,0,0,0,0,0,1,0,0,0);
    mr   = o(0,1,0,0,0,0,0,0,0,0,0);
    mwb  = o(0,0,0,0,1,0,0,0,1,0,1);
    cmpx = o(0,0,0,0,0,1,0,0,0,0,1);
    exm  = o(0,0,0,0,0,4,0,0,0,0,0);

    add(32'h0A000002, 4'b0000, 3, 2, 1, cf, cd, br(0), cf, cf);       // BEQ, flags cleared by reset
    add(32'hE0821003, 4'b0000, 4, 0, 0, cf, cd, exr(0), wb(1,0), cf); // ADD
    add(32'hE0521003, 4'b0100, 4, 0, 0, cf, cd, exr(1), wb(1,0), cf); // SUBS -> Z
    add(32'h0A000002, 4'b0000, 3, 2, 1, cf, cd, br(1), cf, cf);       // BEQ taken
    add(32'h1A000002, 4'b0000, 3, 2, 1, cf, cd, br(0), cf, cf);       // BNE not taken
    add(32'hE5921004, 4'b0000, 5, 1, 0, cf, cd, ma, mr, mwb);         // LDR
    add(32'hE5821004, 4'b0000, 4, 1, 2, cf, cd, ma, mw(1), cf);       // STR
    add(32'hEB000004, 4'b0000, 4, 2, 1, cf, cd, lk(1), br(1), cf);    // BL
    add(32'hFB000004, 4'b0000, 4, 2, 1, cf, cd, lk(0), br(0), cf);    // BL never
    add(32'hE1520003, 4'b1001, 3, 0, 0, cf, cd, cmpx, cf, cf);        // CMP -> N,V
    add(32'hAA000002, 4'b0000, 3, 2, 1, cf, cd, br(1), cf, cf);       // BGE taken
    add(32'hBA000002, 4'b1000, 3, 2, 1, cf, cd, br(0), cf, cf);       // BLT not taken
    add(32'hE0121003, 4'b0110, 4, 0, 0, cf, cd, exr(2), wb(1,0), cf); // ANDS -> NZ only
    add(32'h0A000002, 4'b0000, 3, 2, 1, cf, cd, br(1), cf, cf);       // BEQ taken
    add(32'h6A000002, 4'b0000, 3, 2, 1, cf, cd, br(1), cf, cf);       // BVS taken, V kept
    add(32'h2A000002, 4'b0010, 3, 2, 1, cf, cd, br(0), cf, cf);       // BCS not taken
    add(32'h10821003, 4'b0000, 4, 0, 0, cf, cd, exr(0), wb(0,0), cf); // ADDNE fails, full length
    add(32'hE3821003, 4'b0000, 4, 0, 0, cf, cd, exi(3), wb(1,0), cf); // ORR imm
    add(32'hE0010392, 4'b0000, 4, 0, 0, cf, cd, exm, wb(1,0), cf);    // MUL
    add(32'hEC000000, 4'b0000, 2, 3, 0, cf, cdu, cf, cf, cf);         // undefined -> NOP
    add(32'hE082F003, 4'b0000, 4, 0, 0, cf, cd, exr(0), wb(1,1), cf); // ADD to PC
    add(32'hE0221003, 4'b0000, 4, 0, 0, cf, cd, exr(0), wb(0,0), cf); // EOR unsupported

    Reset    = 1'b0;
    Instr    = 32'h0;
    ALUFlags = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check1("reset_pcwrite", 32'(PCWrite), 32'd0);
    check1("reset_irwrite", 32'(IRWrite), 32'd0);
    check1("reset_wr_done", 32'({RegWrite, MemWrite, InstrDone}), 32'd0);
    check1("reset_srcb",    32'(ALUSrcB), 32'd2);
    Reset = 1'b1;
    #1;
    check1("release_fetch", 32'(act_ctl()), 32'(cf));

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // reset while an ADDS is in EXECR
    Instr    = 32'hE0921003;
    ALUFlags = 4'b0100;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check1("adds_execr", 32'(act_ctl()), 32'(exr(0)));
    Reset = 1'b0;
    #1;
    check1("midrst_writes", 32'({PCWrite, IRWrite, RegWrite, MemWrite, InstrDone}), 32'd0);
    check1("midrst_fetch_sel", 32'({ALUSrcA, ALUSrcB, ResultSrc}), 32'b11010);
    @(posedge clk); #1;
    check1("midrst_hold", 32'({PCWrite, IRWrite, RegWrite, MemWrite, InstrDone}), 32'd0);
    Reset = 1'b1;
    #1;
    check1("midrst_release", 32'(act_ctl()), 32'(cf));
    run_vec(100, vecs[0]);
    run_vec(101, vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle successor to the single-cycle ARM control unit: same decoder and condition semantics, but drives a shared-memory multicycle datapath through a Moore FSM.
- Holds the architectural NZCV flags and gates all architectural write enables with the condition check.
- Optional multiply and branch-with-link support are selected by parameters.
- Sits between the instruction register and the multicycle datapath, one instance per core.

Parameters:
ENABLE_MUL, 0, 1 adds a MUL path (Op=00, I=0, Instr[7:4]=1001) via state EXMUL; 0 decodes MUL as an ordinary data-processing op.
ENABLE_BL, 0, 1 makes B with Instr[24]=1 write PC_instr+4 into R14 via state LINK; 0 ignores Instr[24].

Ports:
clk  input  1  clock, all state changes on rising edge
Reset  input  1  asynchronous, active-low reset
Instr  input  32  instruction register contents
ALUFlags  input  4  N,Z,C,V from the ALU in the current cycle
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register enable
ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
ALUControl  output  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL
ALUSrcA  output  1  0=RD1, 1=PC
ALUSrcB  output  2  00=RD2/ExtImm-shifted, 01=ExtImm, 10=const 4, 11=const 0
ImmSrc  output  2  00 imm8, 01 imm12, 10 imm24
RegSrc  output  2  same meaning as single-cycle RegSrc
RegWrite  output  1  register file write enable
WA3Src  output  1  0=Rd, 1=R14
InstrDone  output  1  one-cycle pulse in the final state of each instruction

Behaviour:
Reset
- While Reset=0: state=FETCH, Flags=0000.
- PCWrite, IRWrite, RegWrite, MemWrite and InstrDone are forced to 0; mux selects hold their FETCH values.
- First FETCH executes on the first rising edge after Reset deasserts.
- Reset mid-instruction abandons the instruction; no partial writes occur after assertion.

States and outputs (unlisted outputs are 0 or don't-care)
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 unconditionally. Next state: DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ADD (PC+8 available on R15 read).
  - Op=01 -> MEMADR.
  - Op=00: I=1 -> EXECI; I=0 -> EXECR, or EXMUL if ENABLE_MUL and MUL pattern.
  - Op=10 -> LINK if ENABLE_BL and Instr[24]=1, else BRANCH.
  - Op=11 -> FETCH, with InstrDone=1 (undefined instruction treated as NOP).
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Next: MEMREAD if L=Instr[20]=1, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx. PCWrite=CondEx if Rd=15. InstrDone=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=CondEx, InstrDone=1. Next: FETCH.
- EXECR / EXECI: ALUSrcA=0, ALUSrcB=00 (EXECR) or 01 (EXECI).
  - ALUControl from Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP(SUB).
  - Any other code: ADD, no writes.
  - Flags update at end of cycle when S=1 and CondEx: NZ always; CV only for ADD/SUB/CMP.
  - Next: ALUWB, or FETCH with InstrDone=1 for CMP (NoWrite).
- EXMUL: ALUSrcA=0, ALUSrcB=00, MUL. S=1 updates NZ only. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=CondEx. PCWrite=CondEx if Rd=15. InstrDone=1. Next: FETCH.
- LINK: ALUSrcA=1, ALUSrcB=11, ADD, ResultSrc=10, WA3Src=1, RegWrite=CondEx. Next: BRANCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx, InstrDone=1. Next: FETCH.

Condition evaluation
- CondEx = f(Instr[31:28], registered Flags), standard ARM table.
- 1110 -> 1; 1111 -> 0.
- Evaluated from registered flags, never from the ALUFlags of the same cycle.

Latency
- LDR 5, STR 4, DP 4, CMP 3, MUL 4, B 3, BL 4 cycles.
- A failed condition does not shorten the sequence; only the writes are suppressed.

Decomposition:
- Package mc_ctrl_pkg: state enum (4-bit encoding), ALUControl codes, ResultSrc/ALUSrcB codes, condition-code constants.
- Sub-module mc_cond_unit: flags register (async active-low reset), CondEx logic, and the FlagW/CondEx gating of the write enables.

Test Plan:
- Reset=0 for 3 cycles, then release: PCWrite/IRWrite=0 during reset; first edge after release shows FETCH outputs with IRWrite=1; Flags=0000.
- ADD R1,R2,R3 (0xE0821003): states FETCH-DECODE-EXECR-ALUWB; RegWrite=1 only in ALUWB; InstrDone pulses in cycle 4.
- SUBS then BEQ: SUBS with ALUFlags=0100 sets Z. Next BEQ (0x0A000002) asserts PCWrite in BRANCH. BNE (0x1A000002) gives PCWrite=0 but still InstrDone.
- LDR (0xE5921004): MEMREAD AdrSrc=1, MEMWB ResultSrc=01, RegWrite=1, 5-cycle total. STR (0xE5821004): MemWrite=1 in MEMWRITE only.
- ENABLE_BL=1, BL (0xEB000004): LINK with WA3Src=1 and RegWrite=1, then BRANCH with PCWrite=1. Repeat with Cond=1111: no writes at all.
- Assert Reset during EXECR of ADDS: state=FETCH immediately; no RegWrite and no flag update; normal fetch resumes after release.
